data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 1024: RAM size in 32-bit words, byte-addressed from 0x0000_0000.
REQ-002 Parameter INIT_FILE, default "": hex image loaded into RAM at elaboration if non-empty.
REQ-003 Parameter MMIO_BASE, default 32'h0000_8000: base of the memory-mapped register block.
REQ-004 CLK  input  1  single clock, all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 RAM_ADD  input  32  byte address from core.
REQ-007 RAM_WDATA  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 MEM_READ  input  1  load request, same cycle.
REQ-009 MEM_WRITE  input  1  store request, committed at next rising edge.
REQ-010 FUNCT3  input  3  RV32I load/store width code.
REQ-011 RAM_DATA  output  32  load result, extended per FUNCT3.
REQ-012 MISALIGN  output  1  current access is misaligned.
REQ-013 LEDS  output  8  LED register contents.

Function
REQ-014 Loads combinational (zero latency): RAM_DATA valid in the same cycle as RAM_ADD/MEM_READ, as the single-cycle core requires.
REQ-015 Load decode: 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext; other codes return 0.
REQ-016 Byte/half lane selected by RAM_ADD[1:0], little-endian.
REQ-017 Stores: 000 SB, 001 SH, 010 SW write only the addressed lanes at the rising edge; other codes write nothing.
REQ-018 MISALIGN=1 when half access with RAM_ADD[0]=1 or word access with RAM_ADD[1:0]!=0, gated by MEM_READ|MEM_WRITE.
REQ-019 Misaligned access: write suppressed, RAM_DATA=0.
REQ-020 MEM_READ=0: RAM_DATA=0.
REQ-021 MEM_READ and MEM_WRITE same cycle, same address: RAM_DATA returns pre-write contents; new data visible next cycle.
REQ-022 Address outside RAM and MMIO: read 0, write ignored, MISALIGN still computed.
REQ-023 MMIO_BASE+0 LED register: SW writes RAM_WDATA[7:0] to LEDS; reads return {24'b0,LEDS}.
REQ-024 MMIO_BASE+4 cycle counter, 32 bits: increments by 1 every cycle, wraps 0xFFFF_FFFF -> 0.
REQ-025 SW to counter loads RAM_WDATA; load wins over increment that cycle; increments from loaded value next cycle.
REQ-026 MMIO accepts word accesses only; sub-word MMIO reads return 0, sub-word writes ignored.

Reset
REQ-027 RST asserted: LEDS=0, counter=0 immediately, regardless of clock.
REQ-028 RAM contents not reset; stores with RST asserted are ignored.
REQ-029 RST released mid-operation: counter reads 0 in first cycle after release, 1 in the next.

Structure
REQ-030 Package data_mem_pkg: FUNCT3 load/store enum, MMIO offsets, default DEPTH.
REQ-031 Sub-module data_mem_align: load lane extract/extend and store byte-enable/data replication; data_mem_resp holds RAM array, MMIO registers, address decode.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD.
REQ-033 SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 -> 0xDEAD55EF.
REQ-034 SW @0x22 -> MISALIGN=1, LW @0x20 unchanged; LH @0x21 -> MISALIGN=1, RAM_DATA=0.
REQ-035 SW 0xFFFFFFFE to MMIO_BASE+4, then LW on following cycles -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-036 SW 0x1A5 to MMIO_BASE -> LEDS=0xA5; assert RST asynchronously mid-cycle -> LEDS=0 before next edge.
REQ-037 Same-cycle LW+SW 0x12345678 @0x40 holding 0x0 -> RAM_DATA=0 that cycle, 0x12345678 next cycle.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory / MMIO response block.
// Holds the RV32I width codes, MMIO register offsets and the lane geometry.
package data_mem_pkg;

  localparam int NUM_LANES     = 4;
  localparam int VEC_W         = 8;
  localparam int DEFAULT_DEPTH = 1024;

  localparam logic [31:0] MMIO_LED_OFS = 32'h0000_0000;
  localparam logic [31:0] MMIO_CNT_OFS = 32'h0000_0004;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Low two funct3 bits give the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) ||
           ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Lane steering between the 32-bit RAM word and the core: load extract/extend,
// store byte enables and store data replication across the byte lanes.
module data_mem_align
  import data_mem_pkg::*;
(
  input  logic [2:0]                      funct3,
  input  logic [1:0]                      off,
  input  logic [31:0]                     rword,
  input  logic [31:0]                     wdata,
  output logic [31:0]                     ldata,
  output logic [NUM_LANES-1:0]            be,
  output logic [NUM_LANES-1:0][VEC_W-1:0] wlanes
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[8*off +: 8];
  assign rhalf = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ldata = '0;
    case (funct3)
      F3_B:    ldata = {{24{rbyte[7]}}, rbyte};
      F3_H:    ldata = {{16{rhalf[15]}}, rhalf};
      F3_W:    ldata = rword;
      F3_BU:   ldata = {24'b0, rbyte};
      F3_HU:   ldata = {16'b0, rhalf};
      default: ldata = '0;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LI = 2'(i);
    always_comb begin
      be[i]     = 1'b0;
      wlanes[i] = wdata[VEC_W*i +: VEC_W];
      case (funct3)
        F3_B: begin
          be[i]     = (off == LI);
          wlanes[i] = wdata[7:0];
        end
        F3_H: begin
          be[i]     = (off[1] == LI[1]);
          wlanes[i] = wdata[VEC_W*(i%2) +: VEC_W];
        end
        F3_W:    be[i] = 1'b1;
        default: be[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Single-cycle data memory for the core: combinational loads, edge-committed
// stores, plus an LED register and free-running cycle counter mapped at MMIO_BASE.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] MMIO_BASE = 32'h0000_8000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] RAM_ADD,
  input  logic [31:0] RAM_WDATA,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  output logic [31:0] RAM_DATA,
  output logic        MISALIGN,
  output logic [7:0]  LEDS
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [33:0] RAM_BYTES = 34'(DEPTH) << 2;

  logic [31:0] mem [0:DEPTH-1];

  mem_req_t    req;
  logic        sel_led, sel_cnt, in_ram, we_ok, mmio_we;
  logic [AW-1:0] idx;
  logic [31:0] rword, ldata;
  logic [7:0]  leds;
  logic [31:0] cnt;
  logic [NUM_LANES-1:0]            be;
  logic [NUM_LANES-1:0][VEC_W-1:0] wlanes;

  assign req = '{rd: MEM_READ, wr: MEM_WRITE, funct3: FUNCT3,
                 addr: RAM_ADD, wdata: RAM_WDATA};

  assign MISALIGN = (req.rd | req.wr) && misaligned(req.funct3, req.addr[1:0]);
  assign sel_led  = (req.addr == MMIO_BASE + MMIO_LED_OFS);
  assign sel_cnt  = (req.addr == MMIO_BASE + MMIO_CNT_OFS);
  assign in_ram   = ({2'b00, req.addr} < RAM_BYTES) && !sel_led && !sel_cnt;
  assign idx      = req.addr[AW+1:2];
  assign rword    = in_ram ? mem[idx] : '0;

  // Stores are dropped while reset is held so a core running into reset
  // cannot corrupt RAM.
  assign we_ok   = req.wr && !MISALIGN && !RST;
  assign mmio_we = req.wr && !MISALIGN && (req.funct3 == F3_W);

  data_mem_align u_align (
    .funct3 (req.funct3),
    .off    (req.addr[1:0]),
    .rword  (rword),
    .wdata  (req.wdata),
    .ldata  (ldata),
    .be     (be),
    .wlanes (wlanes)
  );

  always_comb begin
    RAM_DATA = '0;
    if (req.rd && !MISALIGN) begin
      if (in_ram)
        RAM_DATA = ldata;
      else if (req.funct3 == F3_W && sel_led)
        RAM_DATA = {24'b0, leds};
      else if (req.funct3 == F3_W && sel_cnt)
        RAM_DATA = cnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (we_ok && in_ram) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (be[i]) mem[idx][VEC_W*i +: VEC_W] <= wlanes[i];
    end
  end

  // A counter store overrides that cycle's increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      leds <= '0;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      if (mmio_we && sel_cnt) cnt  <= req.wdata;
      if (mmio_we && sel_led) leds <= req.wdata[7:0];
    end
  end

  assign LEDS = leds;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: loads/stores, alignment, MMIO, reset.
module tb_data_mem_resp;

  localparam logic [31:0] MB = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] add, wdata, rdata;
  logic        rd, wr, mis;
  logic [2:0]  f3;
  logic [7:0]  leds;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH(1024), .MMIO_BASE(MB)) dut (
    .CLK(clk), .RST(rst), .RAM_ADD(add), .RAM_WDATA(wdata),
    .MEM_READ(rd), .MEM_WRITE(wr), .FUNCT3(f3),
    .RAM_DATA(rdata), .MISALIGN(mis), .LEDS(leds)
  );

  // Drive one access; called just after a falling edge.
  task automatic drv(input logic r, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; f3 = f; add = a; wdata = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drv(1, 0, 3'b010, MB + 4, 0);
    repeat (2) @(negedge clk);
    #1;
    total++; if (leds !== 8'h00) begin $display("FAIL rst_leds got=%h exp=00", leds); bad++; end
    total++; if (rdata !== 32'h0) begin $display("FAIL rst_cnt got=%h exp=0", rdata); bad++; end
    @(negedge clk); rst = 1'b0; #1;
    total++; if (rdata !== 32'h0) begin $display("FAIL rel_cnt0 got=%h exp=0", rdata); bad++; end
    @(negedge clk); #1;
    total++; if (rdata !== 32'h1) begin $display("FAIL rel_cnt1 got=%h exp=1", rdata); bad++; end
  endtask

  task automatic test_loads;
    @(negedge clk); drv(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    @(negedge clk); drv(1, 0, 3'b000, 32'h13, 0); #1;
    total++; if (rdata !== 32'hFFFFFFDE) begin $display("FAIL lb13 got=%h exp=ffffffde", rdata); bad++; end
    drv(1, 0, 3'b100, 32'h13, 0); #1;
    total++; if (rdata !== 32'h000000DE) begin $display("FAIL lbu13 got=%h exp=000000de", rdata); bad++; end
    drv(1, 0, 3'b001, 32'h12, 0); #1;
    total++; if (rdata !== 32'hFFFFDEAD) begin $display("FAIL lh12 got=%h exp=ffffdead", rdata); bad++; end
    drv(1, 0, 3'b101, 32'h12, 0); #1;
    total++; if (rdata !== 32'h0000DEAD) begin $display("FAIL lhu12 got=%h exp=0000dead", rdata); bad++; end
    drv(1, 0, 3'b001, 32'h10, 0); #1;
    total++; if (rdata !== 32'hFFFFBEEF) begin $display("FAIL lh10 got=%h exp=ffffbeef", rdata); bad++; end
    drv(1, 0, 3'b000, 32'h10, 0); #1;
    total++; if (rdata !== 32'hFFFFFFEF) begin $display("FAIL lb10 got=%h exp=ffffffef", rdata); bad++; end
    drv(1, 0, 3'b100, 32'h11, 0); #1;
    total++; if (rdata !== 32'h000000BE) begin $display("FAIL lbu11 got=%h exp=000000be", rdata); bad++; end
    drv(1, 0, 3'b010, 32'h10, 0); #1;
    total++; if (rdata !== 32'hDEADBEEF) begin $display("FAIL lw10 got=%h exp=deadbeef", rdata); bad++; end
    drv(1, 0, 3'b011, 32'h10, 0); #1;
    total++; if (rdata !== 32'h0) begin $display("FAIL f3_011 got=%h exp=0", rdata); bad++; end
    drv(0, 0, 3'b010, 32'h10, 0); #1;
    total++; if (rdata !== 32'h0) begin $display("FAIL no_read got=%h exp=0", rdata); bad++; end
  endtask

  task automatic test_store_sub;
    @(negedge clk); drv(0, 1, 3'b000, 32'h11, 32'h0000AB55);
    @(negedge clk); drv(1, 0, 3'b010, 32'h10, 0); #1;
    total++; if (rdata !== 32'hDEAD55EF) begin $display("FAIL sb11 got=%h exp=dead55ef", rdata); bad++; end
    @(negedge clk); drv(0, 1, 3'b001, 32'h12, 32'h99991234);
    @(negedge clk); drv(1, 0, 3'b010, 32'h10, 0); #1;
    total++; if (rdata !== 32'h123455EF) begin $display("FAIL sh12 got=%h exp=123455ef", rdata); bad++; end
    @(negedge clk); drv(0, 1, 3'b011, 32'h10, 32'h0);
    @(negedge clk); drv(1, 0, 3'b010, 32'h10, 0); #1;
    total++; if (rdata !== 32'h123455EF) begin $display("FAIL st011 got=%h exp=123455ef", rdata); bad++; end
  endtask

  task automatic test_misalign;
    @(negedge clk); drv(0, 1, 3'b010, 32'h20, 32'hCAFEF00D);
    @(negedge clk); drv(0, 1, 3'b010, 32'h22, 32'h11111111); #1;
    total++; if (mis !== 1'b1) begin $display("FAIL sw22_mis got=%b exp=1", mis); bad++; end
    @(negedge clk); drv(1, 0, 3'b010, 32'h20, 0); #1;
    total++; if (rdata !== 32'hCAFEF00D) begin $display("FAIL lw20 got=%h exp=cafef00d", rdata); bad++; end
    total++; if (mis !== 1'b0) begin $display("FAIL lw20_mis got=%b exp=0", mis); bad++; end
    drv(1, 0, 3'b001, 32'h21, 0); #1;
    total++; if (mis !== 1'b1) begin $display("FAIL lh21_mis got=%b exp=1", mis); bad++; end
    total++; if (rdata !== 32'h0) begin $display("FAIL lh21_data got=%h exp=0", rdata); bad++; end
    drv(1, 0, 3'b000, 32'h23, 0); #1;
    total++; if (mis !== 1'b0) begin $display("FAIL lb23_mis got=%b exp=0", mis); bad++; end
    drv(0, 0, 3'b010, 32'h22, 0); #1;
    total++; if (mis !== 1'b0) begin $display("FAIL idle_mis got=%b exp=0", mis); bad++; end
    @(negedge clk); drv(0, 1, 3'b001, 32'h23, 32'h0000BBBB);
    @(negedge clk); drv(1, 0, 3'b010, 32'h20, 0); #1;
    total++; if (rdata !== 32'hCAFEF00D) begin $display("FAIL sh23_supp got=%h exp=cafef00d", rdata); bad++; end
  endtask

  task automatic test_out_of_range;
    @(negedge clk); drv(0, 1, 3'b010, 32'h0, 32'hA5A5A5A5);
    @(negedge clk); drv(0, 1, 3'b010, 32'h1000, 32'h5A5A5A5A);
    @(negedge clk); drv(1, 0, 3'b010, 32'h0, 0); #1;
    total++; if (rdata !== 32'hA5A5A5A5) begin $display("FAIL oor_alias got=%h exp=a5a5a5a5", rdata); bad++; end
    drv(1, 0, 3'b010, 32'h1000, 0); #1;
    total++; if (rdata !== 32'h0) begin $display("FAIL oor_read got=%h exp=0", rdata); bad++; end
    drv(1, 0, 3'b010, 32'h1002, 0); #1;
    total++; if (mis !== 1'b1) begin $display("FAIL oor_mis got=%b exp=1", mis); bad++; end
  endtask

  task automatic test_counter;
    @(negedge clk); drv(0, 1, 3'b010, MB + 4, 32'hFFFFFFFE);
    @(negedge clk); drv(1, 0, 3'b010, MB + 4, 0); #1;
    total++; if (rdata !== 32'hFFFFFFFE) begin $display("FAIL cnt0 got=%h exp=fffffffe", rdata); bad++; end
    @(negedge clk); #1;
    total++; if (rdata !== 32'hFFFFFFFF) begin $display("FAIL cnt1 got=%h exp=ffffffff", rdata); bad++; end
    @(negedge clk); #1;
    total++; if (rdata !== 32'h0) begin $display("FAIL cnt_wrap got=%h exp=0", rdata); bad++; end
    drv(1, 0, 3'b100, MB + 4, 0); #1;
    total++; if (rdata !== 32'h0) begin $display("FAIL cnt_sub got=%h exp=0", rdata); bad++; end
  endtask

  task automatic test_leds;
    @(negedge clk); drv(0, 1, 3'b010, 32'h30, 32'h0BADF00D);
    @(negedge clk); drv(0, 1, 3'b010, MB, 32'h000001A5);
    @(negedge clk); drv(1, 0, 3'b010, MB, 0); #1;
    total++; if (leds !== 8'hA5) begin $display("FAIL leds got=%h exp=a5", leds); bad++; end
    total++; if (rdata !== 32'h000000A5) begin $display("FAIL leds_rd got=%h exp=000000a5", rdata); bad++; end
    @(negedge clk); drv(0, 1, 3'b000, MB, 32'h3C);
    @(negedge clk); drv(1, 0, 3'b000, MB, 0); #1;
    total++; if (leds !== 8'hA5) begin $display("FAIL leds_sb got=%h exp=a5", leds); bad++; end
    total++; if (rdata !== 32'h0) begin $display("FAIL leds_lb got=%h exp=0", rdata); bad++; end
    @(negedge clk); drv(0, 1, 3'b010, 32'h30, 32'h77777777);
    #2 rst = 1'b1; #1;
    total++; if (leds !== 8'h00) begin $display("FAIL async_rst got=%h exp=00", leds); bad++; end
    @(negedge clk); drv(1, 0, 3'b010, 32'h30, 0); rst = 1'b0; #1;
    total++; if (rdata !== 32'h0BADF00D) begin $display("FAIL rst_store got=%h exp=0badf00d", rdata); bad++; end
    drv(1, 0, 3'b010, MB + 4, 0); #1;
    total++; if (rdata !== 32'h0) begin $display("FAIL rel2_cnt0 got=%h exp=0", rdata); bad++; end
    @(negedge clk); #1;
    total++; if (rdata !== 32'h1) begin $display("FAIL rel2_cnt1 got=%h exp=1", rdata); bad++; end
  endtask

  task automatic test_same_cycle;
    @(negedge clk); drv(0, 1, 3'b010, 32'h40, 32'h0);
    @(negedge clk); drv(1, 1, 3'b010, 32'h40, 32'h12345678); #1;
    total++; if (rdata !== 32'h0) begin $display("FAIL rw_same got=%h exp=0", rdata); bad++; end
    @(negedge clk); drv(1, 0, 3'b010, 32'h40, 0); #1;
    total++; if (rdata !== 32'h12345678) begin $display("FAIL rw_next got=%h exp=12345678", rdata); bad++; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    drv(0, 0, 3'b000, 0, 0);
    test_reset;
    test_loads;
    test_store_sub;
    test_misalign;
    test_out_of_range;
    test_counter;
    test_leds;
    test_same_cycle;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
